// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the immediate-generation stage.
// The master drives the upstream entry and out_ready. The slave (the stage) drives
// in_ready and the result.
interface imm_extend_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      in_imm_src;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_illegal
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate decode + PC-relative target stage.
// A two-entry OUT/SKID buffer lets the stage accept at full rate under backpressure.
// in_ready depends only on SKID occupancy, so it has no combinational path from out_ready.
module imm_extend_stage #(
  parameter int XLEN = 32  // 32 or 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  imm_extend_stage_if.slave bus
);

  typedef struct packed {
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] imm;
  } entry_t;

  logic [31:0]     imm32;
  logic            illegal_dec;
  logic [XLEN-1:0] imm_ext;
  entry_t          in_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic accept;
  logic drain;
  logic out_free;

  // The opcode field plays no part in immediate selection.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^bus.in_instr[6:0];

  // Decode the immediate into a 32-bit sign-extended form; undefined selects yield zero.
  always_comb begin
    imm32       = '0;
    illegal_dec = 1'b0;
    case (bus.in_imm_src)
      3'b000: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      3'b001: imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      3'b010: imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                       bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      3'b011: imm32 = {bus.in_instr[31:12], 12'b0};
      3'b100: imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                       bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      3'b101: imm32 = {27'b0, bus.in_instr[19:15]};
      default: begin
        imm32       = '0;
        illegal_dec = 1'b1;
      end
    endcase
  end

  // Widen to XLEN. Bit 31 is already the correct sign for every format (zero for Z).
  generate
    if (XLEN == 64) begin : g_ext64
      assign imm_ext = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
      assign imm_ext = imm32;
    end
  endgenerate

  assign in_entry.imm     = imm_ext;
  assign in_entry.target  = bus.in_pc + imm_ext;
  assign in_entry.illegal = illegal_dec;

  assign accept   = bus.in_valid && !skid_valid_q;
  assign drain    = out_valid_q && bus.out_ready;
  assign out_free = !out_valid_q || drain;

  // Next-state for OUT/SKID: a SKID refill of OUT takes precedence over a new input.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset clearing valids and data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_target  = out_q.target;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: decode table, directed handshake
// sequences, and randomized traffic against a queue-based reference model.
module tb_imm_extend_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic flush;
  logic flush64;

  imm_extend_stage_if #(.XLEN(32)) bus32 ();
  imm_extend_stage_if #(.XLEN(64)) bus64 ();

  imm_extend_stage #(.XLEN(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus32)
  );

  imm_extend_stage #(.XLEN(64)) u_dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush64),
    .bus     (bus64)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  vec_t tbl32[11];
  vec_t tbl64[2];
  exp_t sb[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference immediate as a signed value built from field weights (64-bit result).
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, output logic ill);
    longint v;
    ill = 1'b0;
    case (src)
      3'd0: v = longint'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
      3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 64'd4096 : 64'd0);
      3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                - (ins[31] ? 64'd4096 : 64'd0);
      3'd3: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'h1_0000_0000 : 64'd0);
      3'd4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
                - (ins[31] ? 64'h10_0000 : 64'd0);
      3'd5: v = longint'(ins[19:15]);
      default: begin
        v   = 0;
        ill = 1'b1;
      end
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mk_i(input int k);
    return (32'(k) << 20) | 32'h13;
  endfunction

  task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [31:0] pc);
    bus32.in_valid   = v;
    bus32.in_instr   = ins;
    bus32.in_imm_src = src;
    bus32.in_pc      = pc;
  endtask

  task automatic apply32(input vec_t v, input int idx);
    logic [31:0] pc32;
    pc32 = v.pc[31:0];
    drive32(1'b1, v.instr, v.src, pc32);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("tbl32_%0d_valid", idx), {63'd0, bus32.out_valid}, 64'd1);
    check($sformatf("tbl32_%0d_imm", idx), {32'd0, bus32.out_imm}, {32'd0, v.imm[31:0]});
    check($sformatf("tbl32_%0d_target", idx), {32'd0, bus32.out_target}, {32'd0, v.tgt[31:0]});
    check($sformatf("tbl32_%0d_illegal", idx), {63'd0, bus32.out_illegal}, {63'd0, v.ill});
    $display("tbl32 %0d: instr=%08h src=%0d imm=%08h target=%08h ill=%0b",
             idx, v.instr, v.src, bus32.out_imm, bus32.out_target, bus32.out_illegal);
    @(posedge clk); #1;
  endtask

  task automatic apply64(input vec_t v, input int idx);
    bus64.in_valid   = 1'b1;
    bus64.in_instr   = v.instr;
    bus64.in_imm_src = v.src;
    bus64.in_pc      = v.pc;
    bus64.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("tbl64_%0d_valid", idx), {63'd0, bus64.out_valid}, 64'd1);
    check($sformatf("tbl64_%0d_imm", idx), bus64.out_imm, v.imm);
    check($sformatf("tbl64_%0d_target", idx), bus64.out_target, v.tgt);
    check($sformatf("tbl64_%0d_illegal", idx), {63'd0, bus64.out_illegal}, {63'd0, v.ill});
    $display("tbl64 %0d: instr=%08h src=%0d imm=%016h target=%016h",
             idx, v.instr, v.src, bus64.out_imm, bus64.out_target);
    @(posedge clk); #1;
  endtask

  task automatic check_out32(input string name, input logic v, input logic rdy, input int k);
    check({name, "_valid"}, {63'd0, bus32.out_valid}, {63'd0, v});
    check({name, "_in_ready"}, {63'd0, bus32.in_ready}, {63'd0, rdy});
    if (v) check({name, "_imm"}, {32'd0, bus32.out_imm}, 64'(k));
    $display("%s: out_valid=%0b in_ready=%0b imm=%08h", name, bus32.out_valid, bus32.in_ready, bus32.out_imm);
  endtask

  initial begin
    logic        acc;
    logic        xfer;
    logic        ill;
    logic [63:0] imm64;
    exp_t        e;

    tbl32[0]  = '{32'hFFF00093, 3'd0, 64'h100,      64'hFFFFFFFF, 64'h000000FF, 1'b0};
    tbl32[1]  = '{32'hFE000EE3, 3'd2, 64'h1000,     64'hFFFFFFFC, 64'h00000FFC, 1'b0};
    tbl32[2]  = '{32'h123450B7, 3'd3, 64'h0,        64'h12345000, 64'h12345000, 1'b0};
    tbl32[3]  = '{32'h0010006F, 3'd4, 64'h200,      64'h00000800, 64'h00000A00, 1'b0};
    tbl32[4]  = '{32'h000FD073, 3'd5, 64'h300,      64'h0000001F, 64'h0000031F, 1'b0};
    tbl32[5]  = '{32'hFE112C23, 3'd1, 64'h500,      64'hFFFFFFF8, 64'h000004F8, 1'b0};
    tbl32[6]  = '{32'hFFFFFFFF, 3'd6, 64'h40,       64'h0,        64'h40,       1'b1};
    tbl32[7]  = '{32'h00500093, 3'd0, 64'h40,       64'h5,        64'h45,       1'b0};
    tbl32[8]  = '{32'h12345678, 3'd7, 64'h80,       64'h0,        64'h80,       1'b1};
    tbl32[9]  = '{32'hFFF00093, 3'd0, 64'h0,        64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0};
    tbl32[10] = '{32'h800000B7, 3'd3, 64'h80000000, 64'h80000000, 64'h0,        1'b0};
    tbl64[0]  = '{32'h800000B7, 3'd3, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl64[1]  = '{32'h000FD073, 3'd5, 64'hFFFFFFFFFFFFFFF0, 64'h1F, 64'h000000000000000F, 1'b0};

    // Reset held two cycles with traffic offered.
    reset_n = 1'b0;
    flush   = 1'b0;
    flush64 = 1'b0;
    drive32(1'b1, 32'hFFF00093, 3'd0, 32'h100);
    bus32.out_ready  = 1'b1;
    bus64.in_valid   = 1'b0;
    bus64.in_instr   = '0;
    bus64.in_imm_src = '0;
    bus64.in_pc      = '0;
    bus64.out_ready  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    check("rst_imm", {32'd0, bus32.out_imm}, 64'd0);
    check("rst_target", {32'd0, bus32.out_target}, 64'd0);
    check("rst_illegal", {63'd0, bus32.out_illegal}, 64'd0);
    check("rst64_imm", bus64.out_imm, 64'd0);
    $display("reset: out_valid=%0b in_ready=%0b", bus32.out_valid, bus32.in_ready);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    @(posedge clk); #1;

    // Decode table.
    for (int i = 0; i < 11; i++) apply32(tbl32[i], i);
    for (int i = 0; i < 2; i++) apply64(tbl64[i], i);

    // Backpressure: A, B, C streamed while downstream stalls.
    bus32.out_ready = 1'b0;
    drive32(1'b1, mk_i(1), 3'd0, 32'h0);
    @(posedge clk); #1;
    drive32(1'b1, mk_i(2), 3'd0, 32'h0);
    @(negedge clk); check_out32("bp_c1", 1'b1, 1'b1, 1);
    @(posedge clk); #1;
    drive32(1'b1, mk_i(3), 3'd0, 32'h0);
    @(negedge clk); check_out32("bp_c2", 1'b1, 1'b0, 1);
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    @(negedge clk); check_out32("bp_c3", 1'b1, 1'b0, 1);
    @(posedge clk); #1;
    @(negedge clk); check_out32("bp_c4", 1'b1, 1'b1, 2);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(negedge clk); check_out32("bp_c5", 1'b1, 1'b1, 3);
    @(posedge clk); #1;
    @(negedge clk); check_out32("bp_c6", 1'b0, 1'b1, 0);
    @(posedge clk); #1;

    // Flush with OUT and SKID both full and an input offered.
    bus32.out_ready = 1'b0;
    drive32(1'b1, mk_i(17), 3'd0, 32'h0);
    @(posedge clk); #1;
    drive32(1'b1, mk_i(34), 3'd0, 32'h0);
    @(posedge clk); #1;
    drive32(1'b1, mk_i(51), 3'd0, 32'h0);
    flush = 1'b1;
    @(negedge clk); check_out32("fl_full", 1'b1, 1'b0, 17);
    @(posedge clk); #1;
    flush = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk); check_out32("fl_after1", 1'b0, 1'b1, 0);
    @(posedge clk); #1;
    @(negedge clk); check_out32("fl_after2", 1'b0, 1'b1, 0);
    @(posedge clk); #1;
    drive32(1'b1, mk_i(119), 3'd0, 32'h0);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(negedge clk); check_out32("fl_next", 1'b1, 1'b1, 119);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      flush   = ($urandom_range(0, 99) == 0);
      drive32(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), $urandom);
      bus32.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      check("rnd_out_valid", {63'd0, bus32.out_valid}, {63'd0, sb.size() > 0});
      check("rnd_in_ready", {63'd0, bus32.in_ready}, {63'd0, sb.size() < 2});
      if (sb.size() > 0) begin
        check("rnd_imm", {32'd0, bus32.out_imm}, {32'd0, sb[0].imm});
        check("rnd_target", {32'd0, bus32.out_target}, {32'd0, sb[0].tgt});
        check("rnd_illegal", {63'd0, bus32.out_illegal}, {63'd0, sb[0].ill});
      end
      if (!reset_n || flush) begin
        sb.delete();
      end else begin
        acc  = bus32.in_valid && (sb.size() < 2);
        xfer = (sb.size() > 0) && bus32.out_ready;
        if (xfer) void'(sb.pop_front());
        if (acc) begin
          imm64 = ref_imm(bus32.in_instr, bus32.in_imm_src, ill);
          e.imm = imm64[31:0];
          e.tgt = bus32.in_pc + imm64[31:0];
          e.ill = ill;
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end

    // Drain what remains and confirm the stage empties.
    reset_n = 1'b1;
    flush   = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("drain_out_valid", {63'd0, bus32.out_valid}, {63'd0, sb.size() > 0});
      if (sb.size() > 0) begin
        check("drain_imm", {32'd0, bus32.out_imm}, {32'd0, sb[0].imm});
        void'(sb.pop_front());
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
